// File: rtl/serial_add_32b_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_32b_pkg
// Shared definitions for the bit-serial adder:
//   WIDTH   - operand/result width in bits
//   CNT_W   - bit-counter width, clog2(WIDTH)
//   state_e - controller state encoding
//   maj3    - majority-of-three, i.e. the carry function of a full adder
// ---------------------------------------------------------------------------
package serial_add_32b_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_32b_full.sv
// ---------------------------------------------------------------------------
// add_full
// One-bit full adder. Same port order as the subtractor's sub_full cell.
// Ports:
//   S     out  sum bit, A ^ B ^ C_in
//   C_out out  carry out, majority(A, B, C_in)
//   A     in   operand bit
//   B     in   operand bit
//   C_in  in   carry in
// ---------------------------------------------------------------------------
module add_full
    import serial_add_32b_pkg::*;
(
    output logic S,
    output logic C_out,
    input  logic A,
    input  logic B,
    input  logic C_in
);

    assign S     = A ^ B ^ C_in;
    assign C_out = maj3(A, B, C_in);

endmodule

// File: rtl/serial_add_32b.sv
// ---------------------------------------------------------------------------
// serial_add_32b
// Bit-serial adder computing O = A + B + C_in, one bit per clock, LSB first,
// through a single full-adder cell. A start/busy/done handshake frames each
// 32-cycle operation.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   request, sampled only while busy is low
//   A, B   in   operands, captured on an accepted start
//   C_in   in   carry into bit 0, captured on an accepted start
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when O/C_out/V become valid
//   O      out  sum, held until the next result lands
//   C_out  out  carry out of bit 31
//   V      out  signed overflow, carry into bit 31 XOR carry out
// ---------------------------------------------------------------------------
module serial_add_32b
    import serial_add_32b_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] O,
    output logic             C_out,
    output logic             V
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             c_out_q, c_out_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_next;

    // The single full-adder cell works on the current LSBs and the carry flop.
    add_full u_add_full (
        .S     (sum_bit),
        .C_out (carry_next),
        .A     (a_q[0]),
        .B     (b_q[0]),
        .C_in  (carry_q)
    );

    // Next-state logic for controller, datapath shift registers and flags.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        c_out_d = c_out_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            // DONE behaves like IDLE for acceptance, so a start in the done
            // cycle chains straight into the next operation.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = C_in;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                // Sum bits enter at the MSB so bit 0 ends up at the bottom
                // after WIDTH shifts.
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    o_d     = {sum_bit, res_q[WIDTH-1:1]};
                    c_out_d = carry_next;
                    // carry_q here is the carry into the top bit.
                    v_d     = carry_q ^ carry_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            o_q     <= {WIDTH{1'b0}};
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            c_out_q <= c_out_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign O     = o_q;
    assign C_out = c_out_q;
    assign V     = v_q;

endmodule

// File: tb/tb_serial_add_32b.sv
// ---------------------------------------------------------------------------
// tb_serial_add_32b
// Directed and random operations; expected results come from plain 33-bit
// arithmetic and are queued at issue time, then checked by a monitor that
// fires on every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_add_32b;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        C_in = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] O;
    logic        C_out;
    logic        V;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_len = 0;

    logic [33:0] exp_q[$];
    int          acc_q[$];
    logic [33:0] exp_v;
    int          acc_v;

    // Last completed result as the bench expects it to be displayed.
    logic [31:0] model_o = 32'd0;
    logic        model_c = 1'b0;
    logic        model_v = 1'b0;

    serial_add_32b dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .C_in  (C_in),
        .busy  (busy),
        .done  (done),
        .O     (O),
        .C_out (C_out),
        .V     (V)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: output stability during RUN, and result/latency on each done.
    always @(negedge clk) begin
        if (reset) begin
            busy_len = 0;
        end else begin
            if (busy) begin
                busy_len++;
                check("stable_during_run", {O, C_out, V}, {model_o, model_c, model_v});
            end
            if (done) begin
                check("busy_low_at_done", busy, 1'b0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1'b1, 1'b0);
                end else begin
                    exp_v = exp_q.pop_front();
                    acc_v = acc_q.pop_front();
                    check("sum_O",   O,     exp_v[33:2]);
                    check("C_out",   C_out, exp_v[1]);
                    check("V",       V,     exp_v[0]);
                    check("latency_edges", cyc - acc_v, 32);
                    check("busy_cycles",   busy_len,    32);
                    model_o = exp_v[33:2];
                    model_c = exp_v[1];
                    model_v = exp_v[0];
                end
                busy_len = 0;
            end
        end
    end

    // Wait for the block to be free, optionally idle, then issue one add.
    // poke > 0 pulses a bogus start that many edges into the RUN phase.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input int gap, input int poke);
        logic [32:0] s;
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 200);
        if (busy) check("wait_free_timeout", 1'b1, 1'b0);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        A = a;
        B = b;
        C_in = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        exp_q.push_back({s[31:0], s[32], (a[31] == b[31]) && (s[31] != a[31])});
        acc_q.push_back(cyc);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        C_in = 1'($urandom_range(0, 1));
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            start = 1'b1;
            A = 32'h12345678;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;

        #1 reset = 1'b1;
        #1;
        check("reset_O",     O,     32'd0);
        check("reset_C_out", C_out, 1'b0);
        check("reset_V",     V,     1'b0);
        check("reset_busy",  busy,  1'b0);
        check("reset_done",  done,  1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        issue(32'h00000005, 32'h00000003, 1'b0, 0, 0);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 0);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 0);
        issue(32'h80000000, 32'h80000000, 1'b0, 0, 0);
        issue(32'h0000000F, 32'h00000000, 1'b1, 2, 9);
        // Lands in the DONE cycle of the previous op.
        issue(32'h00000001, 32'h00000002, 1'b0, 0, 0);

        // Abort mid-run with an asynchronous reset.
        issue(32'h11111111, 32'h22222222, 1'b0, 0, 0);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_O",     O,     32'd0);
        check("abort_C_out", C_out, 1'b0);
        check("abort_V",     V,     1'b0);
        check("abort_busy",  busy,  1'b0);
        check("abort_done",  done,  1'b0);
        exp_q.delete();
        acc_q.delete();
        model_o = 32'd0;
        model_c = 1'b0;
        model_v = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(posedge clk);
        issue(32'hDEADBEEF, 32'h01234567, 1'b1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = {1'b0, ra[30:0]};
            if (i % 4 == 2) rb = ~ra;
            issue(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("all_results_seen", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
